// File: rtl/b01_stream_driver_if.sv
// Operand handshake, serial compare lines and result handshake of the
// b01 stream driver. master = driver side, slave = host/comparator side.
interface b01_stream_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             line1;
  logic             line2;
  logic             dut_reset;
  logic             outp_in;
  logic             overflw_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_outp;
  logic [WIDTH-1:0] res_ovf;
  logic             ovf_any;

  modport master (
    input  in_valid, in_a, in_b, outp_in, overflw_in, res_ready,
    output in_ready, line1, line2, dut_reset, res_valid, res_outp, res_ovf, ovf_any
  );

  modport slave (
    output in_valid, in_a, in_b, outp_in, overflw_in, res_ready,
    input  in_ready, line1, line2, dut_reset, res_valid, res_outp, res_ovf, ovf_any
  );
endinterface

// File: rtl/b01_stream_driver.sv
// Transmit end of the two-line serial compare interface: serialises an
// operand pair LSB-first onto line1/line2, optionally resets the downstream
// comparator first, and gathers its per-bit outp/overflw responses into
// parallel result words held until the consumer takes them.
module b01_stream_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CAP_DELAY = 1,
  parameter bit          RESET_DUT = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  b01_stream_driver_if.master bus
);

  // Counter covers both the bit index and the drain count (CAP_DELAY <= 4).
  localparam int unsigned CW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_SHIFT,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [WIDTH-1:0]             sh_a_q, sh_a_d;
  logic [WIDTH-1:0]             sh_b_q, sh_b_d;
  logic [CAP_DELAY-1:0]         tag_vld_q, tag_vld_d;
  logic [CAP_DELAY-1:0][CW-1:0] tag_idx_q, tag_idx_d;
  logic                         in_ready_q, in_ready_d;
  logic                         line1_q, line1_d;
  logic                         line2_q, line2_d;
  logic                         dut_reset_q, dut_reset_d;
  logic                         res_valid_q, res_valid_d;
  logic [WIDTH-1:0]             res_outp_q, res_outp_d;
  logic [WIDTH-1:0]             res_ovf_q, res_ovf_d;
  logic                         ovf_any_q, ovf_any_d;
  logic                         push;

  // Next-state, serialiser, capture tagging and result assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    in_ready_d  = in_ready_q;
    line1_d     = 1'b0;
    line2_d     = 1'b0;
    dut_reset_d = 1'b0;
    res_valid_d = res_valid_q;
    res_outp_d  = res_outp_q;
    res_ovf_d   = res_ovf_q;
    tag_vld_d   = '0;
    tag_idx_d   = '0;
    push        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          cnt_d      = '0;
          if (RESET_DUT) begin
            state_d     = S_DRST;
            dut_reset_d = 1'b1;
            sh_a_d      = bus.in_a;
            sh_b_d      = bus.in_b;
          end else begin
            state_d = S_SHIFT;
            line1_d = bus.in_a[0];
            line2_d = bus.in_b[0];
            sh_a_d  = bus.in_a >> 1;
            sh_b_d  = bus.in_b >> 1;
          end
        end
      end
      S_DRST: begin
        state_d = S_SHIFT;
        line1_d = sh_a_q[0];
        line2_d = sh_b_q[0];
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
      end
      S_SHIFT: begin
        // Bit cnt_q is on the lines this cycle; tag it for capture.
        push = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          line1_d = sh_a_q[0];
          line2_d = sh_b_q[0];
          sh_a_d  = sh_a_q >> 1;
          sh_b_d  = sh_b_q >> 1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(CAP_DELAY - 1)) begin
          state_d     = S_HOLD;
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A tag reaches the last stage exactly CAP_DELAY cycles after its bit
    // was driven, which is when the comparator response for it is valid.
    tag_vld_d[0] = push;
    tag_idx_d[0] = cnt_q;
    for (int unsigned i = 1; i < CAP_DELAY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    if (tag_vld_q[CAP_DELAY-1]) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (tag_idx_q[CAP_DELAY-1] == CW'(k)) begin
          res_outp_d[k] = bus.outp_in;
          res_ovf_d[k]  = bus.overflw_in;
        end
      end
    end

    ovf_any_d = |res_ovf_d;
  end

  // State and registered outputs; reset discards any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      line1_q     <= 1'b0;
      line2_q     <= 1'b0;
      dut_reset_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_outp_q  <= '0;
      res_ovf_q   <= '0;
      ovf_any_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      in_ready_q  <= in_ready_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      dut_reset_q <= dut_reset_d;
      res_valid_q <= res_valid_d;
      res_outp_q  <= res_outp_d;
      res_ovf_q   <= res_ovf_d;
      ovf_any_q   <= ovf_any_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.line1     = line1_q;
  assign bus.line2     = line2_q;
  assign bus.dut_reset = dut_reset_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_outp  = res_outp_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.ovf_any   = ovf_any_q;

endmodule
